// File: rtl/dcache_bus_agent.sv
// Data-cache side bus agent: two-word block fills and writebacks toward the bus
// controller, plus snoop service (lookup, response, dirty-block transfer to the bus).
module dcache_bus_agent (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_rd,
  input  logic        req_rdx,
  input  logic        req_wb,
  input  logic [31:0] req_addr,
  input  logic [31:0] wb_data0,
  input  logic [31:0] wb_data1,
  output logic [31:0] fill_data0,
  output logic [31:0] fill_data1,
  output logic        fill_done,
  output logic        wb_done,
  output logic [31:0] snp_addr,
  input  logic        snp_hit,
  input  logic        snp_dirty,
  input  logic [31:0] snp_data0,
  input  logic [31:0] snp_data1,
  output logic        snp_inv,
  output logic        snp_clean,
  output logic        dREN,
  output logic        dWEN,
  output logic        cctrans,
  output logic        ccwrite,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] dload,
  input  logic [31:0] ccsnoopaddr,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, RD0, RD1, SNP_LOOK, SNP_RESP, SNP_TX0, SNP_TX1
  } state_t;

  state_t      state_q;
  logic [31:0] snp_addr_q, word0_q, word1_q, fill0_q, fill1_q;
  logic        inv_q, fill_done_q, wb_done_q, snp_inv_q, snp_clean_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      snp_addr_q  <= '0;
      word0_q     <= '0;
      word1_q     <= '0;
      fill0_q     <= '0;
      fill1_q     <= '0;
      inv_q       <= 1'b0;
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      snp_inv_q   <= 1'b0;
      snp_clean_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      snp_inv_q   <= 1'b0;
      snp_clean_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ccwait) begin
            snp_addr_q <= ccsnoopaddr;
            state_q    <= SNP_LOOK;
          // a request is still high during its own done pulse; do not restart it
          end else if (!fill_done_q && !wb_done_q) begin
            if (req_wb)                 state_q <= WB0;
            else if (req_rdx || req_rd) state_q <= RD0;
          end
        end
        WB0: if (!dwait) state_q <= WB1;
        WB1: if (!dwait) begin
          state_q   <= IDLE;
          wb_done_q <= 1'b1;
        end
        RD0: begin
          if (!dwait) begin
            fill0_q <= dload;
            state_q <= RD1;
          end else if (ccwait) begin
            snp_addr_q <= ccsnoopaddr;
            state_q    <= SNP_LOOK;
          end
        end
        RD1: if (!dwait) begin
          fill1_q     <= dload;
          state_q     <= IDLE;
          fill_done_q <= 1'b1;
        end
        SNP_LOOK: state_q <= SNP_RESP;
        SNP_RESP: begin
          word0_q <= snp_data0;
          word1_q <= snp_data1;
          inv_q   <= snp_hit & ccinv;
          if (snp_hit && snp_dirty) begin
            state_q <= SNP_TX0;
          end else if (!ccwait) begin
            state_q   <= IDLE;
            snp_inv_q <= snp_hit & ccinv;
          end
        end
        SNP_TX0: if (!dwait) state_q <= SNP_TX1;
        SNP_TX1: if (!dwait) begin
          state_q     <= IDLE;
          snp_inv_q   <= inv_q;
          snp_clean_q <= ~inv_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus-side outputs decode straight from the registered state.
  always_comb begin
    dREN     = 1'b0;
    dWEN     = 1'b0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    daddr    = '0;
    dstore   = '0;
    snp_addr = '0;
    case (state_q)
      WB0: begin
        dWEN   = 1'b1;
        daddr  = req_addr;
        dstore = wb_data0;
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = req_addr + 32'd4;
        dstore = wb_data1;
      end
      RD0: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = req_rdx;
        daddr   = req_addr;
      end
      RD1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = req_rdx;
        daddr   = req_addr + 32'd4;
      end
      SNP_LOOK: snp_addr = snp_addr_q;
      SNP_RESP: begin
        snp_addr = snp_addr_q;
        cctrans  = 1'b1;
        ccwrite  = snp_hit & snp_dirty;
      end
      SNP_TX0: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr   = snp_addr_q;
        dstore  = word0_q;
      end
      SNP_TX1: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr   = snp_addr_q + 32'd4;
        dstore  = word1_q;
      end
      default: ;
    endcase
  end

  assign fill_data0 = fill0_q;
  assign fill_data1 = fill1_q;
  assign fill_done  = fill_done_q;
  assign wb_done    = wb_done_q;
  assign snp_inv    = snp_inv_q;
  assign snp_clean  = snp_clean_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_bus_agent.sv
// Self-checking bench for dcache_bus_agent: table of directed transactions,
// randomized transactions against a block-level model, and an async reset sequence.
module tb_dcache_bus_agent;

  localparam int K_WB = 0, K_RD = 1, K_RDX = 2, K_SNP = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr, d0, d1, saddr, s0, s1;
    bit          hit, dirty, inv, abort;
    int          w, w1;
    int          e_fill, e_wb, e_inv, e_clean;
  } txn_t;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        req_rd = 0, req_rdx = 0, req_wb = 0;
  logic [31:0] req_addr = 0, wb_data0 = 0, wb_data1 = 0;
  logic [31:0] fill_data0, fill_data1, snp_addr, daddr, dstore;
  logic        fill_done, wb_done, snp_inv, snp_clean;
  logic        snp_hit = 0, snp_dirty = 0;
  logic [31:0] snp_data0 = 0, snp_data1 = 0;
  logic        dREN, dWEN, cctrans, ccwrite, busy;
  logic        dwait = 1, ccwait = 0, ccinv = 0;
  logic [31:0] dload = 0, ccsnoopaddr = 0;

  int checks = 0, failures = 0;
  logic [31:0] m_f0 = 0, m_f1 = 0;
  logic [63:0] ewq[$], etq[$];
  logic [31:0] erq[$];
  txn_t tbl[10];

  dcache_bus_agent dut (
    .CLK(CLK), .nRST(nRST),
    .req_rd(req_rd), .req_rdx(req_rdx), .req_wb(req_wb),
    .req_addr(req_addr), .wb_data0(wb_data0), .wb_data1(wb_data1),
    .fill_data0(fill_data0), .fill_data1(fill_data1),
    .fill_done(fill_done), .wb_done(wb_done),
    .snp_addr(snp_addr), .snp_hit(snp_hit), .snp_dirty(snp_dirty),
    .snp_data0(snp_data0), .snp_data1(snp_data1),
    .snp_inv(snp_inv), .snp_clean(snp_clean),
    .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
    .dload(dload), .ccsnoopaddr(ccsnoopaddr),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Block-level expectations: which beats go on the bus and which pulses occur.
  function automatic txn_t with_pulses(input txn_t t);
    bit snooping;
    snooping  = (t.kind == K_SNP) || t.abort;
    t.e_fill  = (t.kind == K_RD || t.kind == K_RDX) ? 1 : 0;
    t.e_wb    = (t.kind == K_WB) ? 1 : 0;
    t.e_inv   = (snooping && t.hit && t.inv) ? 1 : 0;
    t.e_clean = (snooping && t.hit && t.dirty && !t.inv) ? 1 : 0;
    return t;
  endfunction

  task automatic model(input txn_t t);
    ewq.delete(); erq.delete(); etq.delete();
    if (t.kind == K_WB) begin
      ewq.push_back({t.addr, t.d0});
      ewq.push_back({t.addr + 32'd4, t.d1});
    end
    if (t.kind == K_RD || t.kind == K_RDX) begin
      erq.push_back(t.addr);
      erq.push_back(t.addr + 32'd4);
      m_f0 = t.d0;
      m_f1 = t.d1;
    end
    if (((t.kind == K_SNP) || t.abort) && t.hit && t.dirty) begin
      etq.push_back({t.saddr, t.s0});
      etq.push_back({t.saddr + 32'd4, t.s1});
    end
  endtask

  task automatic run_txn(input txn_t t, input int id);
    int bcnt, resp_n, tail, wlim, nacc;
    bit resp_dirty, seen_busy, fin, abort_pend, abort_chk, tx;
    bit idle_bad, ccwr_bad, overlap, abort_bad;
    int n_fill, n_wb, n_inv, n_clean;
    logic [63:0] wq[$], tq[$];
    logic [31:0] rq[$];
    string p;
    bcnt = 0; resp_n = 0; tail = -1; resp_dirty = 0; seen_busy = 0; fin = 0;
    abort_chk = 0; idle_bad = 0; ccwr_bad = 0; overlap = 0; abort_bad = 0;
    n_fill = 0; n_wb = 0; n_inv = 0; n_clean = 0;
    abort_pend = t.abort;
    p = $sformatf("t%0d", id);
    model(t);
    req_addr = t.addr; wb_data0 = t.d0; wb_data1 = t.d1; ccinv = t.inv;
    case (t.kind)
      K_WB:  req_wb = 1;
      K_RD:  req_rd = 1;
      K_RDX: req_rdx = 1;
      default: begin ccwait = 1; ccsnoopaddr = t.saddr; end
    endcase
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge CLK);
      n_fill += int'(fill_done); n_wb += int'(wb_done);
      n_inv += int'(snp_inv);    n_clean += int'(snp_clean);
      if (int'(fill_done) + int'(wb_done) + int'(snp_inv) + int'(snp_clean) > 1) overlap = 1;
      if (fill_done || wb_done) begin req_rd = 0; req_rdx = 0; req_wb = 0; end
      if (busy) seen_busy = 1;
      if (!busy && (dREN || dWEN || cctrans || ccwrite || daddr != 0 || dstore != 0)) idle_bad = 1;
      if (dREN && (!cctrans || ccwrite !== (t.kind == K_RDX))) ccwr_bad = 1;
      if (abort_chk) begin
        if (dREN || cctrans) abort_bad = 1;
        abort_chk = 0;
      end
      if (t.saddr != 0 && snp_addr == t.saddr) begin
        snp_hit = t.hit; snp_dirty = t.dirty; snp_data0 = t.s0; snp_data1 = t.s1;
      end else begin
        snp_hit = 0; snp_dirty = 0; snp_data0 = 0; snp_data1 = 0;
      end
      if (!busy) begin resp_dirty = 0; resp_n = 0; end
      tx = 0;
      if (cctrans && !dREN && !dWEN) begin
        if (ccwrite && resp_dirty) tx = 1;
        else if (ccwrite) resp_dirty = 1;
        else begin
          resp_n++;
          if (resp_n >= 2) ccwait = 0;
        end
      end
      if (dREN && abort_pend) begin
        ccwait = 1; ccsnoopaddr = t.saddr; abort_pend = 0; abort_chk = 1; dwait = 1; bcnt = 0;
      end else if (dREN || dWEN || tx) begin
        nacc = dREN ? rq.size() : (dWEN ? wq.size() : tq.size());
        wlim = (nacc % 2 == 0) ? t.w : t.w1;
        if (bcnt >= wlim) begin
          dwait = 0; bcnt = 0;
          if (dREN) begin
            rq.push_back(daddr);
            dload = (daddr == t.addr) ? t.d0 : (daddr == t.addr + 32'd4) ? t.d1 : 32'hBAD0BAD0;
          end else if (dWEN) wq.push_back({daddr, dstore});
          else begin
            tq.push_back({daddr, dstore});
            if (tq.size() == 2) ccwait = 0;
          end
        end else begin
          dwait = 1; bcnt++;
        end
      end else begin
        dwait = 1; bcnt = 0;
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) fin = 1;
      end else if (tail < 0 && ((t.kind == K_WB && n_wb > 0) ||
                 ((t.kind == K_RD || t.kind == K_RDX) && n_fill > 0) ||
                 (t.kind == K_SNP && seen_busy && !busy))) tail = 3;
    end
    dwait = 1; ccwait = 0; req_rd = 0; req_rdx = 0; req_wb = 0;
    snp_hit = 0; snp_dirty = 0; snp_data0 = 0; snp_data1 = 0;
    chk({p, "_complete"}, fin, 1);
    chk({p, "_wr_n"}, wq.size(), ewq.size());
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) chk($sformatf("%s_wr%0d", p, i), wq[i], ewq[i]);
    chk({p, "_rd_n"}, rq.size(), erq.size());
    for (int i = 0; i < rq.size() && i < erq.size(); i++) chk($sformatf("%s_rd%0d", p, i), rq[i], erq[i]);
    chk({p, "_tx_n"}, tq.size(), etq.size());
    for (int i = 0; i < tq.size() && i < etq.size(); i++) chk($sformatf("%s_tx%0d", p, i), tq[i], etq[i]);
    chk({p, "_fill_done_n"}, n_fill, t.e_fill);
    chk({p, "_wb_done_n"}, n_wb, t.e_wb);
    chk({p, "_snp_inv_n"}, n_inv, t.e_inv);
    chk({p, "_snp_clean_n"}, n_clean, t.e_clean);
    chk({p, "_fill_data"}, {fill_data0, fill_data1}, {m_f0, m_f1});
    chk({p, "_idle_bus_zero"}, idle_bad, 0);
    chk({p, "_rd_ccwrite"}, ccwr_bad, 0);
    chk({p, "_pulse_overlap"}, overlap, 0);
    if (t.abort) chk({p, "_abort_drop"}, abort_bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int n;
    //          kind   addr           d0        d1        saddr     s0      s1     h d i a  w w1 fill wb inv clean
    tbl[0] = '{K_WB,  32'h100,       32'hA,    32'hB,    32'h0,    0,      0,     0,0,0,0, 2,1, 0,1,0,0};
    tbl[1] = '{K_RDX, 32'h200,       32'h11,   32'h22,   32'h0,    0,      0,     0,0,0,0, 0,0, 1,0,0,0};
    tbl[2] = '{K_SNP, 32'h0,         0,        0,        32'h300,  32'h33, 32'h44,1,1,1,0, 1,1, 0,0,1,0};
    tbl[3] = '{K_SNP, 32'h0,         0,        0,        32'h308,  32'h77, 32'h78,0,0,1,0, 0,0, 0,0,0,0};
    tbl[4] = '{K_RD,  32'h400,       32'h55,   32'h66,   32'h500,  32'h1,  32'h2, 1,0,0,1, 1,0, 1,0,0,0};
    tbl[5] = '{K_SNP, 32'h0,         0,        0,        32'h600,  32'hC0, 32'hC4,1,1,0,0, 0,2, 0,0,0,1};
    tbl[6] = '{K_SNP, 32'h0,         0,        0,        32'h608,  32'h9,  32'h8, 1,0,1,0, 0,0, 0,0,1,0};
    tbl[7] = '{K_WB,  32'hFFFFFFF8,  32'hE0,   32'hE1,   32'h0,    0,      0,     0,0,0,0, 0,0, 0,1,0,0};
    tbl[8] = '{K_RD,  32'hFFFFFFF8,  32'h1,    32'h2,    32'h0,    0,      0,     0,0,0,0, 3,0, 1,0,0,0};
    tbl[9] = '{K_RDX, 32'h800,       32'hF0,   32'hF1,   32'h700,  32'hD0, 32'hD4,1,1,1,1, 1,1, 1,0,1,0};

    #12;
    chk("reset_outputs", |{fill_data0, fill_data1, fill_done, wb_done, snp_addr, snp_inv, snp_clean,
                           dREN, dWEN, cctrans, ccwrite, daddr, dstore}, 0);
    chk("reset_busy", busy, 0);
    @(negedge CLK);
    nRST = 1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], i);

    for (int i = 0; i < 40; i++) begin
      t.kind  = int'($urandom_range(0, 3));
      t.addr  = $urandom() & 32'hFFFFFFF8;
      t.d0    = $urandom(); t.d1 = $urandom();
      t.saddr = ($urandom() & 32'hFFFFFFF8) | 32'h8;
      t.s0    = $urandom(); t.s1 = $urandom();
      t.hit   = 1'($urandom_range(0, 1));
      t.dirty = 1'($urandom_range(0, 1));
      t.inv   = 1'($urandom_range(0, 1));
      t.abort = (t.kind == K_RD || t.kind == K_RDX) && ($urandom_range(0, 1) == 1);
      t.w     = int'($urandom_range(0, 3));
      t.w1    = int'($urandom_range(0, 3));
      t = with_pulses(t);
      run_txn(t, 100 + i);
    end

    // Async reset while the dirty snoop transfer sits in its first word.
    ccwait = 1; ccsnoopaddr = 32'h900; ccinv = 1; dwait = 1;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge CLK);
      if (snp_addr == 32'h900) begin
        snp_hit = 1; snp_dirty = 1; snp_data0 = 32'h5A; snp_data1 = 32'hA5;
      end else begin
        snp_hit = 0; snp_dirty = 0;
      end
      if (cctrans && ccwrite && !dREN && !dWEN) n++;
    end
    chk("rst_reached_tx0", n, 2);
    chk("rst_tx0_daddr", daddr, 32'h900);
    #2 nRST = 0;
    #1;
    chk("rst_async_outputs", |{fill_data0, fill_data1, fill_done, wb_done, snp_addr, snp_inv, snp_clean,
                               dREN, dWEN, cctrans, ccwrite, daddr, dstore}, 0);
    chk("rst_async_busy", busy, 0);
    ccwait = 0; snp_hit = 0; snp_dirty = 0;
    @(negedge CLK);
    nRST = 1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      n += int'(fill_done) + int'(wb_done) + int'(snp_inv) + int'(snp_clean) + int'(busy);
    end
    chk("rst_release_quiet", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_bus_agent.md
DCACHE_BUS_AGENT -- requirements
Module: dcache_bus_agent

Interface
REQ-001 SHALL: CLK  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: req_rd / req_rdx / req_wb  in  1 each  cache requests: block fill shared, fill exclusive (write intent), dirty-block writeback; held high until the matching done pulse.
REQ-004 SHALL: req_addr  in  32  block base address, bits[2:0]=0; wb_data0/wb_data1  in  32  writeback words.
REQ-005 SHALL: fill_data0/fill_data1  out  32  captured fill words; fill_done, wb_done  out  1  one-cycle completion pulses.
REQ-006 SHALL: snp_addr  out  32  tag-lookup address; snp_hit, snp_dirty  in  1; snp_data0/snp_data1  in  32  block contents (valid one cycle after snp_addr).
REQ-007 SHALL: snp_inv, snp_clean  out  1  one-cycle pulses: invalidate line / downgrade M->S.
REQ-008 SHALL: dREN, dWEN, cctrans, ccwrite  out  1; daddr, dstore  out  32  bus-controller request side.
REQ-009 SHALL: dwait, ccwait, ccinv  in  1; dload, ccsnoopaddr  in  32  bus-controller response side.
REQ-010 SHALL: busy  out  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, WB0, WB1, RD0, RD1, SNP_LOOK, SNP_RESP, SNP_TX0, SNP_TX1.
REQ-012 SHALL, in IDLE, use priority ccwait > req_wb > req_rdx > req_rd; ccwait -> SNP_LOOK, req_wb -> WB0, req_rdx/req_rd -> RD0.
REQ-013 SHALL, in WB0/WB1, drive dWEN=1, daddr=req_addr/req_addr+4, dstore=wb_data0/wb_data1; advance WB0->WB1->IDLE on dwait=0; pulse wb_done on WB1 exit.
REQ-014 SHALL, in RD0/RD1, drive dREN=1, cctrans=1, ccwrite=req_rdx, daddr=req_addr/req_addr+4; on dwait=0 capture dload into fill_data0/fill_data1 and advance RD0->RD1->IDLE; pulse fill_done on RD1 exit.
REQ-015 SHALL, in RD0 before any dwait=0, abort on ccwait=1: drop dREN/cctrans same cycle, go to SNP_LOOK, no fill_done; request reissued from IDLE afterwards.
REQ-016 SHALL, once in RD1 or WB*, ignore ccwait until return to IDLE.
REQ-017 SHALL, in SNP_LOOK, register ccsnoopaddr, drive snp_addr from it, stay one cycle, then SNP_RESP.
REQ-018 SHALL, in SNP_RESP, drive cctrans=1, ccwrite=snp_hit&snp_dirty, latch snp_data0/1; if ccwrite -> SNP_TX0 next cycle, else -> IDLE when ccwait=0.
REQ-019 SHALL, in SNP_TX0/TX1, hold cctrans=1, ccwrite=1, daddr=snoop addr/+4, dstore=latched word0/word1, dWEN=0, dREN=0; advance on dwait=0; SNP_TX1 exit -> IDLE.
REQ-020 SHALL pulse snp_inv once per snoop when snp_hit and ccinv=1 sampled in SNP_RESP (issued at snoop end: SNP_RESP exit if clean, SNP_TX1 exit if dirty); else pulse snp_clean on SNP_TX1 exit.
REQ-021 SHALL compute +4 addresses modulo 2^32 (0xFFFFFFF8+4 = 0xFFFFFFFC).
REQ-022 SHALL drive all bus outputs 0 in IDLE and SNP_LOOK; done/inv/clean pulses never overlap.

Reset
REQ-023 SHALL, on nRST=0 in any state, go to IDLE immediately; all outputs 0, fill_data*/latched words 0, no pulses, in-flight transfer discarded.

Verification
REQ-024 SHALL cover: req_wb, addr 0x100, data 0xA/0xB, dwait low 3rd/5th cycle -> daddr 0x100 then 0x104, dstore 0xA then 0xB, one wb_done.
REQ-025 SHALL cover: req_rdx addr 0x200, dload 0x11/0x22 -> ccwrite=1 during RD*, fill_data0/1=0x11/0x22, one fill_done.
REQ-026 SHALL cover: ccwait, ccsnoopaddr 0x300, snp_hit=1, snp_dirty=1, data 0x33/0x44, ccinv=1 -> cctrans=ccwrite=1, dstore 0x33 @0x300, 0x44 @0x304, one snp_inv.
REQ-027 SHALL cover: snoop miss -> cctrans=1, ccwrite=0, no dstore transfer, no snp_inv/snp_clean, IDLE after ccwait=0.
REQ-028 SHALL cover: req_rd in RD0, ccwait=1 before dwait low -> dREN drops next edge, snoop served, read reissued, one fill_done total.
REQ-029 SHALL cover: nRST asserted in SNP_TX0 -> all outputs 0 asynchronously, busy=0, no pulse after release.
